// File: rtl/ca_code_gen_if.sv
// Control/status bundle for the GPS C/A code generator.
// The master drives enable/code_freq/sync; the slave returns the chip outputs.
interface ca_code_gen_if #(
    parameter int ACC_W   = 32,
    parameter int NUM_PRN = 36
);
    logic               enable;
    logic [ACC_W-1:0]   code_freq;
    logic               sync;
    logic [NUM_PRN-1:0] ca_seq;
    logic               chip_strobe;
    logic               epoch;
    logic [9:0]         chip_count;

    modport master (
        output enable, code_freq, sync,
        input  ca_seq, chip_strobe, epoch, chip_count
    );

    modport slave (
        input  enable, code_freq, sync,
        output ca_seq, chip_strobe, epoch, chip_count
    );
endinterface

// File: rtl/ca_code_gen.sv
// GPS L1 C/A Gold-code generator for PRN 1..NUM_PRN.
// A chip-rate NCO carry clocks the shared G1/G2 LFSRs.
module ca_code_gen #(
    parameter int ACC_W   = 32,
    parameter int NUM_PRN = 36
) (
    input logic         clk,
    input logic         reset,
    ca_code_gen_if.slave bus
);

    localparam logic [9:0] LAST_CHIP = 10'd1022;
    localparam logic [9:0] ALL_ONES  = 10'h3FF;

    // G2 phase-select pair {a, b} (stage numbers 1..10) per PRN.
    function automatic logic [7:0] taps(input int prn);
        logic [7:0] t;
        case (prn)
            1:  t = {4'd2, 4'd6};
            2:  t = {4'd3, 4'd7};
            3:  t = {4'd4, 4'd8};
            4:  t = {4'd5, 4'd9};
            5:  t = {4'd1, 4'd9};
            6:  t = {4'd2, 4'd10};
            7:  t = {4'd1, 4'd8};
            8:  t = {4'd2, 4'd9};
            9:  t = {4'd3, 4'd10};
            10: t = {4'd2, 4'd3};
            11: t = {4'd3, 4'd4};
            12: t = {4'd5, 4'd6};
            13: t = {4'd6, 4'd7};
            14: t = {4'd7, 4'd8};
            15: t = {4'd8, 4'd9};
            16: t = {4'd9, 4'd10};
            17: t = {4'd1, 4'd4};
            18: t = {4'd2, 4'd5};
            19: t = {4'd3, 4'd6};
            20: t = {4'd4, 4'd7};
            21: t = {4'd5, 4'd8};
            22: t = {4'd6, 4'd9};
            23: t = {4'd1, 4'd3};
            24: t = {4'd4, 4'd6};
            25: t = {4'd5, 4'd7};
            26: t = {4'd6, 4'd8};
            27: t = {4'd7, 4'd9};
            28: t = {4'd8, 4'd10};
            29: t = {4'd1, 4'd6};
            30: t = {4'd2, 4'd7};
            31: t = {4'd3, 4'd8};
            32: t = {4'd4, 4'd9};
            33: t = {4'd5, 4'd10};
            34: t = {4'd4, 4'd10};
            35: t = {4'd1, 4'd7};
            36: t = {4'd2, 4'd8};
            37: t = {4'd4, 4'd10};
            default: t = {4'd2, 4'd6};
        endcase
        return t;
    endfunction

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [9:0]       g1;
    logic [9:0]       g2;
    logic [9:0]       chip_count;
    logic             chip_strobe;
    logic             epoch;
    logic             g1_fb;
    logic             g2_fb;
    logic             wrap;

    // Bit k holds stage k+1; stage 10 is bit 9.
    assign sum   = {1'b0, acc} + {1'b0, bus.code_freq};
    assign carry = sum[ACC_W];
    assign g1_fb = g1[2] ^ g1[9];
    assign g2_fb = g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9];
    assign wrap  = (chip_count == LAST_CHIP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            g1          <= ALL_ONES;
            g2          <= ALL_ONES;
            chip_count  <= '0;
            chip_strobe <= 1'b0;
            epoch       <= 1'b0;
        end else if (bus.sync) begin
            acc         <= '0;
            g1          <= ALL_ONES;
            g2          <= ALL_ONES;
            chip_count  <= '0;
            chip_strobe <= 1'b0;
            epoch       <= 1'b0;
        end else if (bus.enable) begin
            acc         <= sum[ACC_W-1:0];
            chip_strobe <= carry;
            epoch       <= carry & wrap;
            if (carry) begin
                if (wrap) begin
                    chip_count <= '0;
                    g1         <= ALL_ONES;
                    g2         <= ALL_ONES;
                end else begin
                    chip_count <= chip_count + 10'd1;
                    g1         <= {g1[8:0], g1_fb};
                    g2         <= {g2[8:0], g2_fb};
                end
            end
        end else begin
            chip_strobe <= 1'b0;
            epoch       <= 1'b0;
        end
    end

    generate
        for (genvar i = 0; i < NUM_PRN; i++) begin : g_prn
            localparam logic [7:0] T = taps(i + 1);
            localparam int A = int'(T[7:4]) - 1;
            localparam int B = int'(T[3:0]) - 1;
            assign bus.ca_seq[i] = g1[9] ^ g2[A] ^ g2[B];
        end
    endgenerate

    assign bus.chip_count  = chip_count;
    assign bus.chip_strobe = chip_strobe;
    assign bus.epoch       = epoch;

endmodule

// File: tb/tb_ca_code_gen.sv
// Bench for ca_code_gen: reference code tables built from the Gold-code
// recurrences, plus a chip-timing model driven by NCO carry arithmetic.
module tb_ca_code_gen;
    localparam int ACC_W   = 32;
    localparam int NUM_PRN = 36;
    localparam int CHIPS   = 1023;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ca_code_gen_if #(.ACC_W(ACC_W), .NUM_PRN(NUM_PRN)) bus ();
    ca_code_gen #(.ACC_W(ACC_W), .NUM_PRN(NUM_PRN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tap_a [NUM_PRN] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4,5,4,1,2};
    int tap_b [NUM_PRN] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9,10,10,7,8};

    logic [NUM_PRN-1:0] ref_seq [CHIPS];
    logic [NUM_PRN-1:0] seen    [CHIPS];
    logic               y1 [CHIPS+10];
    logic               y2 [CHIPS+10];

    logic [31:0] macc;
    int          mchip;
    logic        estrobe, eepoch;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Output streams of the LFSRs from the all-ones start: y(n+10) is the
    // xor of the delayed outputs selected by the characteristic polynomial.
    task automatic build_ref();
        for (int n = 0; n < 10; n++) begin
            y1[n] = 1'b1;
            y2[n] = 1'b1;
        end
        for (int n = 0; n < CHIPS; n++) begin
            y1[n+10] = y1[n+7] ^ y1[n];
            y2[n+10] = y2[n+8] ^ y2[n+7] ^ y2[n+4] ^ y2[n+2] ^ y2[n+1] ^ y2[n];
        end
        for (int n = 0; n < CHIPS; n++)
            for (int p = 0; p < NUM_PRN; p++)
                ref_seq[n][p] = y1[n] ^ y2[n+10-tap_a[p]] ^ y2[n+10-tap_b[p]];
    endtask

    task automatic model_reset();
        macc = '0; mchip = 0; estrobe = 1'b0; eepoch = 1'b0;
    endtask

    task automatic model_edge();
        logic [32:0] s;
        if (reset || bus.sync) begin
            model_reset();
        end else if (bus.enable) begin
            s       = {1'b0, macc} + {1'b0, bus.code_freq};
            macc    = s[31:0];
            estrobe = s[32];
            eepoch  = s[32] && (mchip == CHIPS - 1);
            if (s[32]) mchip = (mchip + 1) % CHIPS;
        end else begin
            estrobe = 1'b0;
            eepoch  = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("chip_count", 64'(bus.chip_count), 64'(mchip));
        check("chip_strobe", 64'(bus.chip_strobe), 64'(estrobe));
        check("epoch", 64'(bus.epoch), 64'(eepoch));
        check("ca_seq", 64'(bus.ca_seq), 64'(ref_seq[mchip]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run_to(input int target, input string tag);
        bit hit = 1'b0;
        for (int k = 0; k < 4000 && !hit; k++) begin
            if (bus.chip_count == 10'(target)) hit = 1'b1;
            else tick();
        end
        check(tag, 64'(hit), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int epochs;
    logic [9:0] f0, f1;
    int ones;

    initial begin
        build_ref();
        model_reset();
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.sync      = 1'b0;
        bus.code_freq = '0;
        #1;
        compare_all();
        do_reset();
        compare_all();

        // Half-rate chips from reset for two full epochs.
        for (int c = 0; c < CHIPS; c++) seen[c] = '0;
        bus.code_freq = 32'h8000_0000;
        bus.enable    = 1'b1;
        epochs = 0;
        for (int k = 0; k < 2 * CHIPS; k++) begin
            tick();
            if (k < 2 * CHIPS - 1) seen[bus.chip_count] = bus.ca_seq;
            if (bus.epoch) epochs++;
        end
        check("epoch_count", 64'(epochs), 64'd1);
        check("wrap_chip", 64'(bus.chip_count), 64'd0);
        check("wrap_ones", 64'(bus.ca_seq), 64'({NUM_PRN{1'b1}}));
        for (int c = 0; c < 10; c++) begin
            f0[9-c] = seen[c][0];
            f1[9-c] = seen[c][1];
        end
        check("prn1_first10", 64'(f0), 64'(10'b1100100000));
        check("prn2_first10", 64'(f1), 64'(10'b1110010000));
        for (int p = 0; p < NUM_PRN; p++) begin
            ones = 0;
            for (int c = 0; c < CHIPS; c++) ones += int'(seen[c][p]);
            check($sformatf("ones_prn%0d", p + 1), 64'(ones), 64'd512);
        end

        // Enable gap mid-epoch.
        run_to(500, "reach_500");
        @(negedge clk);
        bus.enable = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("hold_strobe", 64'(bus.chip_strobe), 64'd0);
            check("hold_chip", 64'(bus.chip_count), 64'd500);
        end
        bus.enable = 1'b1;
        for (int k = 0; k < 4 && !bus.chip_strobe; k++) tick();
        check("resume_chip", 64'(bus.chip_count), 64'd501);

        // Sync restart.
        run_to(300, "reach_300");
        bus.sync = 1'b1;
        tick();
        bus.sync = 1'b0;
        check("sync_chip", 64'(bus.chip_count), 64'd0);
        check("sync_ones", 64'(bus.ca_seq), 64'({NUM_PRN{1'b1}}));
        check("sync_epoch", 64'(bus.epoch), 64'd0);
        check("sync_strobe", 64'(bus.chip_strobe), 64'd0);
        tick();
        check("sync_adv1", 64'(bus.chip_strobe), 64'd0);
        tick();
        check("sync_adv2", 64'(bus.chip_strobe), 64'd1);

        // Asynchronous reset between edges at chip 700.
        run_to(700, "reach_700");
        @(posedge clk);
        model_edge();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 24; k++) tick();
        check("post_reset_chip", 64'(bus.chip_count), 64'd12);

        // Maximum increment: carry on every edge but the first.
        do_reset();
        bus.code_freq = 32'hFFFF_FFFF;
        tick();
        check("max_first_nocarry", 64'(bus.chip_strobe), 64'd0);
        for (int k = 0; k < 2 * CHIPS + 4; k++) tick();

        // Random enable, increment and occasional sync.
        for (int blk = 0; blk < 60; blk++) begin
            case ($urandom_range(0, 3))
                0: bus.code_freq = $urandom;
                1: bus.code_freq = 32'h8000_0000 + $urandom_range(0, 32'h7FFF_FFFF);
                2: bus.code_freq = $urandom_range(0, 3) == 0 ? 32'h0 : 32'h1000_0000;
                default: bus.code_freq = 32'hFFFF_FFFF - $urandom_range(0, 255);
            endcase
            for (int k = 0; k < 50; k++) begin
                bus.enable = ($urandom_range(0, 9) < 8);
                bus.sync   = ($urandom_range(0, 199) == 0);
                tick();
            end
        end
        bus.sync = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ca_code_gen.md
CA_CODE_GEN -- requirements
Module: ca_code_gen

Interface
REQ-001 SHALL have parameter ACC_W, default 32: chip-rate NCO accumulator width.
REQ-002 SHALL have parameter NUM_PRN, default 36: PRNs generated in parallel (PRN 1..NUM_PRN).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  advance NCO/code when high; hold all state when low.
REQ-006 SHALL have port code_freq  input  ACC_W  chip NCO increment per clock (1.023 MHz * 2^ACC_W / f_clk, Doppler-adjusted).
REQ-007 SHALL have port sync  input  1  one-cycle pulse restarting code epoch and NCO phase.
REQ-008 SHALL have port ca_seq  output  NUM_PRN  current chip of every PRN; bit i = PRN i+1, 1 = chip '1' (downstream multiplies by -1).
REQ-009 SHALL have port chip_strobe  output  1  one-cycle pulse: ca_seq changed on the previous edge.
REQ-010 SHALL have port epoch  output  1  one-cycle pulse: chip 0 of a new 1023-chip epoch now on ca_seq.
REQ-011 SHALL have port chip_count  output  10  index (0..1022) of the chip currently on ca_seq.

Function
REQ-012 SHALL hold ACC_W-bit phase accumulator acc; each enabled edge acc <= (acc + code_freq) mod 2^ACC_W; carry = unsigned overflow of that sum.
REQ-013 SHALL, on an enabled edge with carry, advance G1 and G2 one shift and increment chip_count on that same edge.
REQ-014 SHALL implement G1 = 10-bit LFSR 1+x^3+x^10, G2 = 10-bit LFSR 1+x^2+x^3+x^6+x^8+x^9+x^10, stages numbered 1..10 per IS-GPS-200.
REQ-015 SHALL form ca_seq[i] = G1[10] xor G2[a] xor G2[b], (a,b) = IS-GPS-200 Table 3-Ia phase-select pair for PRN i+1 (e.g. PRN1 2,6; PRN2 3,7; PRN36 2,8).
REQ-016 SHALL derive ca_seq combinationally from G1/G2 registers only (no extra latency; valid every cycle).
REQ-017 SHALL register chip_strobe: high for exactly the cycle after an enabled edge with carry, else 0.
REQ-018 SHALL wrap chip_count 1022 -> 0 and on that same edge force G1 = G2 = all ones (explicit reload, not relying on LFSR period).
REQ-019 SHALL register epoch: high for exactly the cycle after the 1022 -> 0 wrap edge; chip_strobe also high that cycle.
REQ-020 SHALL, when enable low, hold acc, G1, G2, chip_count; chip_strobe and epoch 0 next cycle.
REQ-021 SHALL give sync priority over enable: on sync edge acc <= 0, G1 = G2 = all ones, chip_count <= 0, chip_strobe <= 0, epoch <= 0.
REQ-022 SHALL treat code_freq = 0 as valid (code frozen); code_freq sampled every cycle, changes take effect next edge without glitching phase.

Reset
REQ-023 SHALL, while reset high, asynchronously set acc = 0, G1 = G2 = 10'b11_1111_1111, chip_count = 0, chip_strobe = 0, epoch = 0.
REQ-024 SHALL therefore present ca_seq = all ones (chip 0 = '1' for every PRN) during and after reset until the first chip advance.
REQ-025 SHALL accept reset assertion mid-epoch with the same result; first advance after release follows REQ-012 from acc = 0.

Verification
REQ-026 Reset release, enable=1, code_freq=32'h8000_0000 -> chip_strobe every 2nd cycle starting the cycle after the 2nd enabled edge; ca_seq[0] chips 0..9 = 1100100000 (octal 1440), ca_seq[1] = 1110010000 (octal 1620).
REQ-027 Same stimulus for 2046 enabled cycles -> epoch pulses once, chip_count reads 0, ca_seq = all ones; each PRN bit is '1' for exactly 512 of the 1023 chips.
REQ-028 Mid-epoch (chip_count=500) drop enable for 7 cycles -> ca_seq, chip_count frozen, no strobes; on re-enable sequence resumes at chip 501 with no lost or repeated chip.
REQ-029 Pulse sync at chip_count=300 with enable=1 -> next cycle chip_count=0, ca_seq all ones, epoch=0, chip_strobe=0; next chip advance 2 cycles later (code_freq=2^31).
REQ-030 code_freq=32'hFFFF_FFFF -> no carry on the 1st enabled edge, carry on every later edge; golden-model compare of all 36 PRNs over 2 epochs, zero mismatches.
REQ-031 Assert reset asynchronously mid-cycle at chip 700 -> outputs reach reset values before the next clk edge; post-release behaviour identical to REQ-026.
